// File: rtl/uart_pkg.sv
// uart_pkg: shared framing constants, FSM state encoding and sizing helper for the frame receiver.
package uart_pkg;
   localparam logic [7:0] SOF = 8'hA5;
   localparam int DEF_MAX_LEN = 16;
   typedef enum logic [2:0] {S_IDLE, S_LEN, S_PAYLOAD, S_CSUM, S_DRAIN} state_e;
   function automatic int addr_w(int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction
endpackage

// File: rtl/uart_frame_rx_if.sv
// uart_frame_rx_if: byte-strobe input, valid/ready payload output and error pulses of the frame receiver.
interface uart_frame_rx_if;
   logic       i_rx_valid;
   logic [7:0] i_rx_byte;
   logic       o_valid;
   logic [7:0] o_data;
   logic       o_last;
   logic       i_ready;
   logic       o_busy;
   logic       o_csum_err;
   logic       o_len_err;
   logic       o_timeout;
   logic       o_overrun;
   modport slave (
      input  i_rx_valid, i_rx_byte, i_ready,
      output o_valid, o_data, o_last, o_busy, o_csum_err, o_len_err, o_timeout, o_overrun
   );
   modport master (
      output i_rx_valid, i_rx_byte, i_ready,
      input  o_valid, o_data, o_last, o_busy, o_csum_err, o_len_err, o_timeout, o_overrun
   );
endinterface

// File: rtl/uart_frame_buf.sv
// uart_frame_buf: payload register file, one synchronous write port and one combinational read port.
module uart_frame_buf #(
   parameter int Depth = 16,
   parameter int AW = 4
) (
   input  logic          i_clk,
   input  logic          i_we,
   input  logic [AW-1:0] i_waddr,
   input  logic [7:0]    i_wdata,
   input  logic [AW-1:0] i_raddr,
   output logic [7:0]    o_rdata
);
   logic [7:0] mem_q [Depth];
   always_ff @(posedge i_clk) if (i_we) mem_q[i_waddr] <= i_wdata;
   assign o_rdata = mem_q[i_raddr];
endmodule

// File: rtl/uart_frame_rx.sv
// uart_frame_rx: parses SOF/LEN/payload/CSUM frames from a byte strobe and replays verified payloads over valid/ready.
module uart_frame_rx
   import uart_pkg::*;
#(
   parameter int ClkFreq = 10_000_000,
   parameter int BaudRate = 115200,
   parameter int MaxLen = DEF_MAX_LEN,
   parameter int TimeoutCycles = 10 * ClkFreq / BaudRate * 10
) (
   input logic            i_clk,
   input logic            i_rst_n,
   uart_frame_rx_if.slave bus
);
   localparam int AW = addr_w(MaxLen);
   localparam int TW = $clog2(TimeoutCycles + 1);
   state_e        state_q, state_d;
   logic [AW-1:0] len_m1_q, len_m1_d, idx_q, idx_d, rd_q, rd_d, rd_addr;
   logic [7:0]    sum_q, sum_d, data_q, data_d, rd_data;
   logic [TW-1:0] tmo_q, tmo_d;
   logic          valid_q, valid_d, last_q, last_d, we, timed;
   logic          csum_err_q, csum_err_d, len_err_q, len_err_d;
   logic          timeout_q, timeout_d, overrun_q, overrun_d;
   uart_frame_buf #(.Depth(MaxLen), .AW(AW)) u_buf (
      .i_clk(i_clk), .i_we(we), .i_waddr(idx_q), .i_wdata(bus.i_rx_byte),
      .i_raddr(rd_addr), .o_rdata(rd_data)
   );
   assign timed = (state_q == S_LEN) || (state_q == S_PAYLOAD) || (state_q == S_CSUM);
   assign rd_addr = (state_q == S_CSUM) ? '0 : rd_q + AW'(1);
   always_comb begin
      state_d = state_q;
      len_m1_d = len_m1_q;
      idx_d = idx_q;
      rd_d = rd_q;
      sum_d = sum_q;
      valid_d = valid_q;
      data_d = data_q;
      last_d = last_q;
      we = 1'b0;
      csum_err_d = 1'b0;
      len_err_d = 1'b0;
      timeout_d = 1'b0;
      overrun_d = 1'b0;
      tmo_d = (timed && !bus.i_rx_valid) ? tmo_q + TW'(1) : '0;
      case (state_q)
         S_IDLE: if (bus.i_rx_valid && bus.i_rx_byte == SOF) state_d = S_LEN;
         S_LEN: if (bus.i_rx_valid) begin
            if (bus.i_rx_byte == 8'd0 || int'(bus.i_rx_byte) > MaxLen) begin
               len_err_d = 1'b1;
               state_d = S_IDLE;
            end else begin
               len_m1_d = AW'(bus.i_rx_byte - 8'd1);
               sum_d = bus.i_rx_byte;
               idx_d = '0;
               state_d = S_PAYLOAD;
            end
         end
         S_PAYLOAD: if (bus.i_rx_valid) begin
            we = 1'b1;
            sum_d = sum_q + bus.i_rx_byte;
            idx_d = idx_q + AW'(1);
            state_d = (idx_q == len_m1_q) ? S_CSUM : S_PAYLOAD;
         end
         S_CSUM: if (bus.i_rx_valid) begin
            if ((sum_q + bus.i_rx_byte) == 8'd0) begin
               state_d = S_DRAIN;
               valid_d = 1'b1;
               rd_d = '0;
               data_d = rd_data;
               last_d = (len_m1_q == '0);
            end else begin
               csum_err_d = 1'b1;
               state_d = S_IDLE;
            end
         end
         S_DRAIN: begin
            // Bytes arriving while the payload drains cannot be buffered, so they are flagged and dropped.
            overrun_d = bus.i_rx_valid;
            if (valid_q && bus.i_ready) begin
               if (last_q) begin
                  valid_d = 1'b0;
                  last_d = 1'b0;
                  state_d = S_IDLE;
               end else begin
                  rd_d = rd_q + AW'(1);
                  data_d = rd_data;
                  last_d = ((rd_q + AW'(1)) == len_m1_q);
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
      if (timed && !bus.i_rx_valid && tmo_q == TW'(TimeoutCycles - 1)) begin
         timeout_d = 1'b1;
         state_d = S_IDLE;
      end
   end
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= S_IDLE;
         len_m1_q <= '0;
         idx_q <= '0;
         rd_q <= '0;
         sum_q <= '0;
         tmo_q <= '0;
         valid_q <= 1'b0;
         data_q <= '0;
         last_q <= 1'b0;
         csum_err_q <= 1'b0;
         len_err_q <= 1'b0;
         timeout_q <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         state_q <= state_d;
         len_m1_q <= len_m1_d;
         idx_q <= idx_d;
         rd_q <= rd_d;
         sum_q <= sum_d;
         tmo_q <= tmo_d;
         valid_q <= valid_d;
         data_q <= data_d;
         last_q <= last_d;
         csum_err_q <= csum_err_d;
         len_err_q <= len_err_d;
         timeout_q <= timeout_d;
         overrun_q <= overrun_d;
      end
   end
   assign bus.o_valid = valid_q;
   assign bus.o_data = data_q;
   assign bus.o_last = last_q;
   assign bus.o_busy = (state_q != S_IDLE);
   assign bus.o_csum_err = csum_err_q;
   assign bus.o_len_err = len_err_q;
   assign bus.o_timeout = timeout_q;
   assign bus.o_overrun = overrun_q;
endmodule

// File: tb/tb_uart_frame_rx.sv
// tb_uart_frame_rx: table vectors, hand-written corner sequences and random frames checked against a frame-level model.
module tb_uart_frame_rx;
   localparam int T = 20;
   localparam int ML = 16;
   logic i_clk = 1'b0;
   logic i_rst_n = 1'b0;
   always #5 i_clk = ~i_clk;
   uart_frame_rx_if bus();
   uart_frame_rx #(.ClkFreq(10_000_000), .BaudRate(115200), .MaxLen(ML), .TimeoutCycles(T)) dut (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .bus(bus.slave)
   );
   int vec = 0, miss = 0;
   int cyc = 0;
   int n_csum = 0, n_len = 0, n_tmo = 0, n_ovr = 0, n_multi = 0, hold_viol = 0;
   int s_c, s_l, s_t, s_o, s_p;
   int ready_mode = 0;
   logic [8:0] out_q[$];
   int stamp_q[$];
   logic [8:0] exp_q[$];
   logic [7:0] stream[$];
   logic pv, pr, pl;
   logic [7:0] pd;
   typedef struct {
      int nb;
      logic [191:0] b;
      int ne;
      logic [127:0] e;
      int csum;
      int len;
   } vec_t;
   vec_t tbl[9];
   always @(posedge i_clk) cyc++;
   always @(posedge i_clk) begin
      #1;
      bus.i_ready = (ready_mode == 0) ? 1'b1 : (ready_mode == 1) ? 1'($urandom_range(0, 1)) :
                    (ready_mode == 2) ? ~bus.i_ready : 1'b0;
   end
   always @(negedge i_clk) begin
      if (!i_rst_n) pv = 1'b0;
      else begin
         if (pv && !pr && (!bus.o_valid || bus.o_data !== pd || bus.o_last !== pl)) hold_viol++;
         if (bus.o_valid && bus.i_ready) begin
            out_q.push_back({bus.o_last, bus.o_data});
            stamp_q.push_back(cyc);
         end
         n_csum += int'(bus.o_csum_err);
         n_len += int'(bus.o_len_err);
         n_tmo += int'(bus.o_timeout);
         n_ovr += int'(bus.o_overrun);
         if (int'(bus.o_csum_err) + int'(bus.o_len_err) + int'(bus.o_timeout) + int'(bus.o_overrun) > 1) n_multi++;
         pv = bus.o_valid;
         pr = bus.i_ready;
         pd = bus.o_data;
         pl = bus.o_last;
      end
   end
   initial begin
      #300000;
      $display("FAIL watchdog: got no end of test, expected end within 300000 ns");
      $fatal(1, "watchdog");
   end
   task automatic check(string name, int act, int exp);
      vec++;
      if (act !== exp) begin
         miss++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask
   task automatic tick(int n);
      repeat (n) begin
         @(posedge i_clk);
         #1;
      end
   endtask
   task automatic send(logic [7:0] b);
      bus.i_rx_valid = 1'b1;
      bus.i_rx_byte = b;
      tick(1);
      bus.i_rx_valid = 1'b0;
   endtask
   task automatic wait_idle(string name);
      int k = 0;
      while (bus.o_busy && k < 500) begin
         tick(1);
         k++;
      end
      check({name, "_idle"}, int'(bus.o_busy), 0);
      tick(2);
   endtask
   task automatic snap();
      s_c = n_csum;
      s_l = n_len;
      s_t = n_tmo;
      s_o = n_ovr;
      s_p = out_q.size();
   endtask
   task automatic errs(string name, int ec, int el, int et, int eo);
      check({name, "_csum_err"}, n_csum - s_c, ec);
      check({name, "_len_err"}, n_len - s_l, el);
      check({name, "_timeout"}, n_tmo - s_t, et);
      check({name, "_overrun"}, n_ovr - s_o, eo);
   endtask
   task automatic expect_out(string name, int ne, logic [127:0] e, bit consec);
      check({name, "_count"}, out_q.size() - s_p, ne);
      for (int i = 0; i < ne; i++) begin
         if (s_p + i < out_q.size()) begin
            logic [8:0] g;
            g = out_q[s_p + i];
            check($sformatf("%s_data%0d", name, i), int'(g[7:0]), int'(e[(ne - 1 - i) * 8 +: 8]));
            check($sformatf("%s_last%0d", name, i), int'(g[8]), int'(i == ne - 1));
            if (consec && i > 0) check($sformatf("%s_gap%0d", name, i), stamp_q[s_p + i] - stamp_q[s_p + i - 1], 1);
         end
      end
   endtask
   function automatic vec_t mk(int nb, logic [191:0] b, int ne, logic [127:0] e, int c, int l);
      vec_t v;
      v.nb = nb;
      v.b = b;
      v.ne = ne;
      v.e = e;
      v.csum = c;
      v.len = l;
      return v;
   endfunction
   task automatic sendr(logic [7:0] b);
      send(b);
      stream.push_back(b);
      tick($urandom_range(0, 3));
   endtask
   function automatic void model(output int ce, output int le);
      int i = 0;
      ce = 0;
      le = 0;
      exp_q.delete();
      while (i < stream.size()) begin
         int len, sum;
         if (stream[i] != 8'hA5) begin
            i++;
            continue;
         end
         if (i + 1 >= stream.size()) break;
         len = int'(stream[i + 1]);
         if (len == 0 || len > ML) begin
            le++;
            i += 2;
            continue;
         end
         if (i + 2 + len >= stream.size()) break;
         sum = len + int'(stream[i + 2 + len]);
         for (int k = 0; k < len; k++) sum += int'(stream[i + 2 + k]);
         if (sum % 256 == 0) for (int k = 0; k < len; k++) exp_q.push_back({k == len - 1, stream[i + 2 + k]});
         else ce++;
         i += 3 + len;
      end
   endfunction
   initial begin
      vec_t v;
      int ce, le;
      bus.i_rx_valid = 1'b0;
      bus.i_rx_byte = 8'h00;
      #12;
      check("rst_valid", int'(bus.o_valid), 0);
      check("rst_data", int'(bus.o_data), 0);
      check("rst_last", int'(bus.o_last), 0);
      check("rst_busy", int'(bus.o_busy), 0);
      check("rst_errs", int'({bus.o_csum_err, bus.o_len_err, bus.o_timeout, bus.o_overrun}), 0);
      tick(1);
      i_rst_n = 1'b1;
      tick(2);
      tbl[0] = mk(6, 192'({8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h97}), 3, 128'({8'h11, 8'h22, 8'h33}), 0, 0);
      tbl[1] = mk(6, 192'({8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h96}), 0, 128'd0, 1, 0);
      tbl[2] = mk(2, 192'({8'hA5, 8'h00}), 0, 128'd0, 0, 1);
      tbl[3] = mk(2, 192'({8'hA5, 8'h11}), 0, 128'd0, 0, 1);
      tbl[4] = tbl[0];
      tbl[5] = mk(6, 192'({8'h00, 8'h37, 8'hA5, 8'h01, 8'hFF, 8'h00}), 1, 128'({8'hFF}), 0, 0);
      tbl[6] = mk(2, 192'({8'hA5, 8'hA5}), 0, 128'd0, 0, 1);
      v = mk(0, 192'd0, 0, 128'd0, 0, 0);
      v.b = {v.b[183:0], 8'hA5};
      v.b = {v.b[183:0], 8'h10};
      for (int k = 0; k < 16; k++) begin
         v.b = {v.b[183:0], 8'(k)};
         v.e = {v.e[119:0], 8'(k)};
      end
      v.b = {v.b[183:0], 8'h78};
      v.nb = 19;
      v.ne = 16;
      tbl[7] = v;
      tbl[8] = mk(4, 192'({8'hA5, 8'h01, 8'h7F, 8'h80}), 1, 128'({8'h7F}), 0, 0);
      for (int r = 0; r < 9; r++) begin
         snap();
         for (int i = 0; i < tbl[r].nb; i++) send(tbl[r].b[(tbl[r].nb - 1 - i) * 8 +: 8]);
         wait_idle($sformatf("row%0d", r));
         expect_out($sformatf("row%0d", r), tbl[r].ne, tbl[r].e, 1'b1);
         errs($sformatf("row%0d", r), tbl[r].csum, tbl[r].len, 0, 0);
      end
      snap();
      ready_mode = 3;
      send(8'hA5); send(8'h02); send(8'h44); send(8'h55); send(8'h65);
      check("lat_valid", int'(bus.o_valid), 1);
      check("lat_data", int'(bus.o_data), 8'h44);
      check("lat_last", int'(bus.o_last), 0);
      tick(3);
      check("stall_valid", int'(bus.o_valid), 1);
      check("stall_data", int'(bus.o_data), 8'h44);
      ready_mode = 0;
      wait_idle("stall");
      expect_out("stall", 2, 128'({8'h44, 8'h55}), 1'b0);
      errs("stall", 0, 0, 0, 0);
      snap();
      send(8'hA5); send(8'h02); send(8'h44);
      tick(T - 1);
      check("tmo_busy_before", int'(bus.o_busy), 1);
      check("tmo_pulse_before", int'(bus.o_timeout), 0);
      tick(1);
      check("tmo_pulse", int'(bus.o_timeout), 1);
      check("tmo_busy_after", int'(bus.o_busy), 0);
      tick(2);
      expect_out("tmo", 0, 128'd0, 1'b0);
      errs("tmo", 0, 0, 1, 0);
      snap();
      send(8'hA5); send(8'h02); send(8'h44);
      tick(T - 1);
      send(8'h55);
      tick(T - 1);
      send(8'h65);
      wait_idle("tmo_edge");
      expect_out("tmo_edge", 2, 128'({8'h44, 8'h55}), 1'b1);
      errs("tmo_edge", 0, 0, 0, 0);
      snap();
      ready_mode = 2;
      send(8'hA5); send(8'h03); send(8'h11); send(8'h22); send(8'h33); send(8'h97);
      check("ovr_busy1", int'(bus.o_busy), 1);
      send(8'hA5);
      tick(1);
      check("ovr_busy2", int'(bus.o_busy), 1);
      send(8'hA5);
      wait_idle("ovr");
      ready_mode = 0;
      expect_out("ovr", 3, 128'({8'h11, 8'h22, 8'h33}), 1'b0);
      errs("ovr", 0, 0, 0, 2);
      tick(2);
      snap();
      send(8'hA5); send(8'h03); send(8'h11); send(8'h22);
      i_rst_n = 1'b0;
      #3;
      check("arst_busy", int'(bus.o_busy), 0);
      check("arst_valid", int'(bus.o_valid), 0);
      check("arst_data", int'(bus.o_data), 0);
      tick(2);
      i_rst_n = 1'b1;
      tick(1);
      send(8'hA5); send(8'h02); send(8'h44); send(8'h55); send(8'h65);
      wait_idle("arst");
      expect_out("arst", 2, 128'({8'h44, 8'h55}), 1'b1);
      errs("arst", 0, 0, 0, 0);
      snap();
      ready_mode = 1;
      for (int f = 0; f < 40; f++) begin
         int nj, kind, len, sum;
         logic [7:0] b, cs;
         nj = $urandom_range(0, 2);
         for (int j = 0; j < nj; j++) begin
            b = 8'($urandom_range(0, 255));
            sendr(b == 8'hA5 ? 8'h00 : b);
         end
         sendr(8'hA5);
         kind = $urandom_range(0, 9);
         len = (kind == 0) ? 0 : (kind == 1) ? $urandom_range(ML + 1, 255) : $urandom_range(1, ML);
         sendr(8'(len));
         if (len >= 1 && len <= ML) begin
            sum = len;
            for (int k = 0; k < len; k++) begin
               b = 8'($urandom_range(0, 255));
               sum += int'(b);
               sendr(b);
            end
            cs = 8'(256 - sum % 256);
            if ($urandom_range(0, 3) == 0) cs = cs ^ (8'h01 << $urandom_range(0, 7));
            sendr(cs);
         end
         wait_idle($sformatf("rnd%0d", f));
      end
      ready_mode = 0;
      model(ce, le);
      check("rnd_count", out_q.size() - s_p, exp_q.size());
      for (int i = 0; i < exp_q.size(); i++) begin
         if (s_p + i < out_q.size()) check($sformatf("rnd_out%0d", i), int'(out_q[s_p + i]), int'(exp_q[i]));
      end
      errs("rnd", ce, le, 0, 0);
      check("one_error_per_cycle", n_multi, 0);
      check("hold_stable", hold_viol, 0);
      $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
      $finish;
   end
endmodule

// File: doc/uart_frame_rx.md
UART_FRAME_RX -- requirements
Module: uart_frame_rx

Interface
REQ-001 Parameter ClkFreq, default 10_000_000, clock frequency in Hz.
REQ-002 Parameter BaudRate, default 115200, line rate, used only to derive the default timeout.
REQ-003 Parameter MaxLen, default 16, maximum payload bytes per frame (range 1..255).
REQ-004 Parameter TimeoutCycles, default 10*ClkFreq/BaudRate*10, idle clocks allowed between bytes inside a frame.
REQ-005 i_clk  input  1  single clock; all logic on posedge.
REQ-006 i_rst_n  input  1  reset, asynchronous, active-low.
REQ-007 i_rx_valid  input  1  one-cycle strobe, received byte available from the UART receiver.
REQ-008 i_rx_byte  input  8  received byte, valid when i_rx_valid=1.
REQ-009 o_valid  output  1  payload byte available downstream.
REQ-010 o_data  output  8  payload byte.
REQ-011 o_last  output  1  o_data is the final payload byte of the frame.
REQ-012 i_ready  input  1  downstream accepts o_data; a transfer occurs when o_valid & i_ready.
REQ-013 o_busy  output  1  high in every state except IDLE.
REQ-014 o_csum_err, o_len_err, o_timeout, o_overrun  output  1 each  one-cycle error pulses.

Function
REQ-015 Frame format: SOF=0xA5, LEN (1..MaxLen), LEN payload bytes, CSUM, where (LEN + payload + CSUM) mod 256 == 0.
REQ-016 FSM states: IDLE, LEN, PAYLOAD, CSUM, DRAIN; each state acts only on cycles with i_rx_valid=1, except DRAIN.
REQ-017 IDLE: byte 0xA5 -> LEN; any other byte is ignored, with no pulse.
REQ-018 LEN: LEN==0 or LEN>MaxLen -> o_len_err pulse on the next cycle, then IDLE; otherwise store the count, seed the running sum with LEN, and go to PAYLOAD.
REQ-019 PAYLOAD: write each byte to the buffer at the write index and add it to the 8-bit running sum (wraps mod 256); after the LENth byte -> CSUM.
REQ-020 CSUM: if (sum + byte) mod 256 == 0 -> DRAIN; otherwise pulse o_csum_err, discard the buffer, and go to IDLE.
REQ-021 Latency: o_valid rises on the cycle after the CSUM byte strobe, with o_data = payload[0].
REQ-022 DRAIN: o_data = payload[rd_idx]; rd_idx advances only on a transfer; o_data and o_last hold stable while o_valid & ~i_ready.
REQ-023 o_last=1 exactly when rd_idx == LEN-1; after that transfer, o_valid drops and the FSM enters IDLE on the next cycle.
REQ-024 Any i_rx_valid seen in DRAIN is dropped and pulses o_overrun; it is never parsed as SOF.
REQ-025 Timeout counter: runs in LEN, PAYLOAD and CSUM; clears on every i_rx_valid and on state entry.
REQ-026 When the counter reaches TimeoutCycles-1 with no byte that cycle -> o_timeout pulse, IDLE, frame discarded.
REQ-027 Byte strobe and timeout terminal count in the same cycle: the byte is processed and the counter clears, so no timeout occurs.
REQ-028 Only one error pulse is asserted per cycle; all error pulses are registered.

Reset
REQ-029 On i_rst_n=0, asynchronously: state=IDLE, all indices/sum/counter=0, o_valid=0, o_last=0, o_data=0x00, o_busy=0, all error pulses=0.
REQ-030 Reset mid-frame or mid-DRAIN abandons the frame; the buffer contents need not be cleared, but no stale byte may ever be presented.

Structure
REQ-031 Shared package uart_pkg holds SOF=0xA5, the FSM state encoding, and the default MaxLen.
REQ-032 The payload store is one sub-module, uart_frame_buf: MaxLen x 8 register file, one synchronous write port, one combinational read port, no reset on the storage.

Verification
REQ-033 Good frame A5 03 11 22 33 97, i_ready=1 -> o_data 11,22,33 on consecutive cycles, o_last on 33, no error pulse.
REQ-034 Same frame with CSUM 0x96 -> exactly one o_csum_err pulse, o_valid never asserted, o_busy=0 afterwards.
REQ-035 A5 00 and A5 11 (MaxLen=16) -> one o_len_err each; a following good frame is received correctly.
REQ-036 A5 02 44 then silence for TimeoutCycles -> one o_timeout, IDLE; a byte arriving on the terminal cycle instead -> no timeout.
REQ-037 Good frame with i_ready toggling 1010, plus A5 bytes injected during DRAIN -> payload intact and ordered, one o_overrun per injected byte.
REQ-038 Assert i_rst_n low during PAYLOAD, then release and send a good frame -> no output from the aborted frame; the new frame is delivered exactly.
